// File: rtl/rv32_mem_arbiter.sv
// Single-port memory arbiter for the priRV32 core.
// Shares one memory port between instruction fetch (I, read-only) and
// load/store (D, read/write). D has priority; a streak counter forces an
// I grant after D_STREAK_MAX back-to-back D grants while I is waiting.
// A watchdog aborts transactions the memory never completes.
module rv32_mem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned D_STREAK_MAX = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                clk,
    input  logic                reset,
    // Instruction-fetch port
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ack,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_err,
    // Load/store port
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err,
    // Memory port
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned SW     = $clog2(D_STREAK_MAX + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam logic [SW-1:0] STREAK_MAX = SW'(D_STREAK_MAX);
    // Abort on the edge where the counter would reach TIMEOUT, so mem_req
    // is high for exactly TIMEOUT cycles.
    localparam logic [7:0]    TMO_LAST   = 8'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic [7:0]        tmo_q, tmo_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
    logic              i_ack_q, i_ack_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic              i_err_q, i_err_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              d_err_q, d_err_d;
    logic              busy_q, busy_d;
    logic              grant_d;

    // D wins unless I has been starved for D_STREAK_MAX grants.
    assign grant_d = d_req && !(i_req && (streak_q == STREAK_MAX));

    // Next-state logic: arbitration, transaction tracking and response capture.
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        tmo_d       = tmo_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        i_ack_d     = 1'b0;
        i_rdata_d   = i_rdata_q;
        i_err_d     = i_err_q;
        d_ack_d     = 1'b0;
        d_rdata_d   = d_rdata_q;
        d_err_d     = d_err_q;

        unique case (state_q)
            IDLE: begin
                tmo_d = 8'd0;
                if (grant_d) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_wstrb_d = d_wstrb;
                    // With i_req high a D grant implies streak < max, so +1 cannot overflow.
                    streak_d    = i_req ? streak_q + SW'(1) : '0;
                    state_d     = BUSY_D;
                end else if (i_req) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = i_addr;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                    streak_d    = '0;
                    state_d     = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                tmo_d = tmo_q + 8'd1;
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                    if (state_q == BUSY_I) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = mem_rdata;
                        i_err_d   = 1'b0;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = mem_we_q ? '0 : mem_rdata;
                        d_err_d   = 1'b0;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                    if (state_q == BUSY_I) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = '0;
                        i_err_d   = 1'b1;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = '0;
                        d_err_d   = 1'b1;
                    end
                end
            end
            RESP: begin
                tmo_d   = 8'd0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset abandons any transaction silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            tmo_q       <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            i_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            i_err_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            tmo_q       <= tmo_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            i_ack_q     <= i_ack_d;
            i_rdata_q   <= i_rdata_d;
            i_err_q     <= i_err_d;
            d_ack_q     <= d_ack_d;
            d_rdata_q   <= d_rdata_d;
            d_err_q     <= d_err_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign i_ack     = i_ack_q;
    assign i_rdata   = i_rdata_q;
    assign i_err     = i_err_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Self-checking bench for rv32_mem_arbiter: directed scenarios followed by
// randomized request/latency traffic, checked against a transaction-level model.
module tb_rv32_mem_arbiter;

    localparam int unsigned TIMEOUT      = 255;
    localparam int unsigned D_STREAK_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int m_streak = 0;

    rv32_mem_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .D_STREAK_MAX (D_STREAK_MAX),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .i_err     (i_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: who wins given the requests currently presented.
    task automatic pick(output logic win_d);
        if (d_req && i_req) win_d = (m_streak != D_STREAK_MAX);
        else                win_d = d_req;
        if (win_d && i_req) m_streak = (m_streak < D_STREAK_MAX) ? m_streak + 1 : m_streak;
        else                m_streak = 0;
    endtask

    task automatic raise_i();
        i_req  = 1'b1;
        i_addr = $urandom & 32'hFFFF_FFFC;
    endtask

    task automatic raise_d();
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(1, 0));
        d_addr  = $urandom & 32'hFFFF_FFFC;
        d_wdata = $urandom;
        d_wstrb = 4'($urandom_range(15, 0));
    endtask

    // Run one transaction starting from an IDLE cycle with requests already driven.
    // lat < 0: memory never answers (timeout); otherwise lat extra wait cycles.
    task automatic do_txn(input int lat, input logic [31:0] rd);
        logic        wd;
        logic        ewe;
        logic        eerr;
        logic [31:0] ea;
        logic [31:0] ewd;
        logic [31:0] erd;
        logic [3:0]  ews;
        int          nbusy;
        pick(wd);
        if (wd) begin
            ea = d_addr; ewe = d_we; ewd = d_wdata; ews = d_wstrb;
        end else begin
            ea = i_addr; ewe = 1'b0; ewd = 32'h0; ews = 4'h0;
        end
        eerr  = (lat < 0);
        erd   = ((lat < 0) || (wd && ewe)) ? 32'h0 : rd;
        nbusy = (lat < 0) ? int'(TIMEOUT) : lat + 1;
        for (int c = 1; c <= nbusy; c++) begin
            tick();
            chk("mem_req_busy", 32'(mem_req), 32'd1);
            chk("busy_busy", 32'(busy), 32'd1);
            chk("acks_busy", 32'({i_ack, d_ack}), 32'd0);
            if (c == 1 || c == nbusy) begin
                chk("mem_addr", mem_addr, ea);
                chk("mem_we", 32'(mem_we), 32'(ewe));
                chk("mem_wstrb", 32'(mem_wstrb), 32'(ews));
                if (wd) chk("mem_wdata", mem_wdata, ewd);
            end
            if (lat >= 0 && c == nbusy) begin
                mem_ready = 1'b1;
                mem_rdata = rd;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
            end
        end
        tick();
        chk("i_ack_resp", 32'(i_ack), 32'(!wd));
        chk("d_ack_resp", 32'(d_ack), 32'(wd));
        chk("mem_req_resp", 32'(mem_req), 32'd0);
        chk("busy_resp", 32'(busy), 32'd1);
        if (wd) begin
            chk("d_rdata", d_rdata, erd);
            chk("d_err", 32'(d_err), 32'(eerr));
            d_req = 1'b0;
        end else begin
            chk("i_rdata", i_rdata, erd);
            chk("i_err", 32'(i_err), 32'(eerr));
            i_req = 1'b0;
        end
        // mem_ready is noise outside BUSY and must be ignored
        mem_ready = 1'($urandom_range(1, 0));
        mem_rdata = $urandom;
        tick();
        chk("busy_idle", 32'(busy), 32'd0);
        chk("acks_idle", 32'({i_ack, d_ack}), 32'd0);
        chk("mem_req_idle", 32'(mem_req), 32'd0);
        mem_ready = 1'($urandom_range(1, 0));
    endtask

    initial begin
        logic wd;
        reset     = 1'b1;
        i_req     = 1'b0;
        i_addr    = 32'h0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = 32'h0;
        d_wdata   = 32'h0;
        d_wstrb   = 4'h0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        tick();
        tick();
        chk("rst_outs", 32'({i_ack, i_err, d_ack, d_err, mem_req, mem_we, busy}), 32'd0);
        chk("rst_i_rdata", i_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
        reset = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // Plain fetch
        i_req  = 1'b1;
        i_addr = 32'h0000_0010;
        do_txn(0, 32'h0000_0013);

        // Simultaneous requests: D store first, then I
        i_req   = 1'b1;
        i_addr  = 32'h0000_0100;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h8000_0000;
        d_wdata = 32'h0000_00A5;
        d_wstrb = 4'h1;
        do_txn(0, $urandom);
        do_txn(0, $urandom);

        // Fetch starvation guard: D re-raised after every ack while I waits
        raise_i();
        for (int n = 0; n < 6; n++) begin
            if (!d_req) raise_d();
            do_txn(0, $urandom);
        end
        while (i_req || d_req) do_txn(0, $urandom);

        // Watchdog abort, then a normal read
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_2000;
        do_txn(-1, $urandom);
        raise_d();
        d_we = 1'b0;
        do_txn(1, $urandom);

        // mem_ready stuck high while idle
        mem_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("stuck_ready_acks", 32'({i_ack, d_ack}), 32'd0);
            chk("stuck_ready_busy", 32'(busy), 32'd0);
        end
        raise_d();
        do_txn(0, $urandom);

        // Reset during BUSY_I abandons the fetch
        i_req  = 1'b1;
        i_addr = 32'h0000_0440;
        pick(wd);
        tick();
        chk("rst_mid_mem_req", 32'(mem_req), 32'd1);
        chk("rst_mid_addr", mem_addr, 32'h0000_0440);
        reset     = 1'b1;
        mem_ready = 1'b1;
        tick();
        chk("rst_mid_after_req", 32'(mem_req), 32'd0);
        chk("rst_mid_after_busy", 32'(busy), 32'd0);
        chk("rst_mid_after_ack", 32'({i_ack, d_ack}), 32'd0);
        reset     = 1'b0;
        mem_ready = 1'b0;
        m_streak  = 0;
        do_txn(2, $urandom);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            if (!i_req && $urandom_range(1, 0) == 1) raise_i();
            if (!d_req && $urandom_range(1, 0) == 1) raise_d();
            if (!i_req && !d_req) begin
                tick();
                chk("rand_idle_busy", 32'(busy), 32'd0);
                chk("rand_idle_acks", 32'({i_ack, d_ack}), 32'd0);
            end else begin
                do_txn(int'($urandom_range(3, 0)), $urandom);
            end
        end
        while (i_req || d_req) do_txn(0, $urandom);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
